cpu_boot_ctrl: RTL and testbench

Host-side sequencer that owns the external memory ports and `enable` of the `cpu` top. On `start` it streams a program into instruction memory and an initial image into data memory, runs the core for a programmed number of cycles, then streams a window of data memory back to the host. It is the only driver of the `cpu` external ports in the test harness and FPGA wrapper.

---
 rtl/cpu_boot_pkg.sv | 41 ++++
 rtl/cpu_boot_if.sv | 20 ++
 rtl/boot_phase_counter.sv | 27 ++
 rtl/cpu_boot_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_cpu_boot_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_boot_pkg.sv
// cpu_boot_pkg: boot sequencer states, memory strides and default widths.
// CPU_BOOT_DUMP_EN adds the dmem read-back states.
package cpu_boot_pkg;

  localparam int IMEM_AW_DEF = 9;
  localparam int DMEM_AW_DEF = 10;
  localparam int CNT_W_DEF   = 32;
  localparam int IMEM_STRIDE = 4;
  localparam int DMEM_STRIDE = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_I,
    LOAD_D,
    RUN,
`ifdef CPU_BOOT_DUMP_EN
    DUMP_RD,
    DUMP_WAIT,
    DUMP_OUT,
`endif
    DONE
  } state_e;

`ifdef CPU_BOOT_DUMP_EN
  localparam state_e DUMP_ENTRY = DUMP_RD;
`else
  localparam state_e DUMP_ENTRY = DONE;
`endif

  // nz: {dump, run, dmem, imem} phases still ahead with a non-zero count
  function automatic state_e next_phase(input logic [3:0] nz);
    state_e s;
    s = DONE;
    if (nz[3]) s = DUMP_ENTRY;
    if (nz[2]) s = RUN;
    if (nz[1]) s = LOAD_D;
    if (nz[0]) s = LOAD_I;
    return s;
  endfunction

endpackage

// File: rtl/cpu_boot_if.sv
// cpu_boot_if: host load (in_*) and dump (out_*) valid/ready streams.
// master is the host side, slave is cpu_boot_ctrl.
interface cpu_boot_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/boot_phase_counter.sv
// boot_phase_counter: loadable down-counter, last flags a count of one.
// A reload wins over a decrement in the same cycle.
module boot_phase_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         dec,
  output logic         last
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld) cnt_d = ld_val;
    else if (dec) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign last = (cnt_q == W'(1));
endmodule

// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl: streams imem/dmem images in, runs the core, dumps dmem.
// Define CPU_BOOT_DUMP_EN to build the dmem read-back phase.
module cpu_boot_ctrl
  import cpu_boot_pkg::*;
#(
  parameter int IMEM_ADDR_W = IMEM_AW_DEF,
  parameter int DMEM_ADDR_W = DMEM_AW_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [IMEM_ADDR_W:0] imem_words,
  input  logic [DMEM_ADDR_W:0] dmem_words,
  input  logic [CNT_W-1:0]     run_cycles,
  input  logic [DMEM_ADDR_W:0] dump_words,
  cpu_boot_if.slave            host,
  output logic                 enable,
  output logic [63:0]          addr_ext,
  output logic                 wen_ext,
  output logic                 ren_ext,
  output logic [31:0]          wdata_ext,
  output logic [63:0]          addr_ext_2,
  output logic                 wen_ext_2,
  output logic                 ren_ext_2,
  output logic [63:0]          wdata_ext_2,
  input  logic [63:0]          rdata_ext_2,
  output logic                 busy,
  output logic                 done
);
  localparam int WW = DMEM_ADDR_W + 1;

  state_e st_q, st_d, nxt;
  logic [DMEM_ADDR_W-1:0] idx_q, idx_d;
  logic [IMEM_ADDR_W:0] imem_n_q, imem_n_d;
  logic [DMEM_ADDR_W:0] dmem_n_q, dmem_n_d;
  logic [DMEM_ADDR_W:0] dump_n_q, dump_n_d;
  logic [CNT_W-1:0] run_n_q, run_n_d;
  logic [3:0] nz, mask;
  logic [WW-1:0] wc_val;
  logic enter, in_fire, out_fire, dump_nz;
  logic wc_dec, wc_last, rc_dec, rc_last;
  logic ld_i, ld_d, dm_addr_on;

  // counts track the inputs while idle, so they freeze on start
  always_comb begin
    imem_n_d = (st_q == IDLE) ? imem_words : imem_n_q;
    dmem_n_d = (st_q == IDLE) ? dmem_words : dmem_n_q;
    run_n_d  = (st_q == IDLE) ? run_cycles : run_n_q;
    dump_n_d = (st_q == IDLE) ? dump_words : dump_n_q;
`ifdef CPU_BOOT_DUMP_EN
    dump_nz  = |dump_n_d;
`else
    dump_nz  = 1'b0;
`endif
    nz = {dump_nz, |run_n_d, |dmem_n_d, |imem_n_d};
  end

  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    mask   = '0;
    enter  = 1'b0;
    wc_dec = 1'b0;
    rc_dec = 1'b0;
    unique case (st_q)
      IDLE: begin
        idx_d = '0;
        if (start) begin
          enter = 1'b1;
          mask  = 4'b1111;
        end
      end
      LOAD_I, LOAD_D: if (in_fire) begin
        wc_dec = 1'b1;
        idx_d  = idx_q + DMEM_ADDR_W'(1);
        if (wc_last) begin
          idx_d = '0;
          enter = 1'b1;
          mask  = ld_i ? 4'b1110 : 4'b1100;
        end
      end
      RUN: begin
        rc_dec = 1'b1;
        if (rc_last) begin
          enter = 1'b1;
          mask  = 4'b1000;
        end
      end
`ifdef CPU_BOOT_DUMP_EN
      DUMP_RD:   st_d = DUMP_WAIT;
      DUMP_WAIT: st_d = DUMP_OUT;
      DUMP_OUT: if (out_fire) begin
        wc_dec = 1'b1;
        idx_d  = idx_q + DMEM_ADDR_W'(1);
        st_d   = DUMP_RD;
        if (wc_last) begin
          idx_d = '0;
          st_d  = DONE;
        end
      end
`endif
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
    nxt = next_phase(nz & mask);
    if (enter) st_d = nxt;
    if (abort) begin
      st_d  = IDLE;
      idx_d = '0;
    end
  end

  always_comb begin
    case (nxt)
      LOAD_I:  wc_val = WW'(imem_n_d);
      LOAD_D:  wc_val = dmem_n_d;
`ifdef CPU_BOOT_DUMP_EN
      DUMP_RD: wc_val = dump_n_d;
`endif
      default: wc_val = '0;
    endcase
  end

  boot_phase_counter #(.W(WW)) u_word_cnt (
    .clk    (clk),
    .rst_n  (arst_n),
    .ld     (enter),
    .ld_val (wc_val),
    .dec    (wc_dec),
    .last   (wc_last)
  );

  boot_phase_counter #(.W(CNT_W)) u_run_cnt (
    .clk    (clk),
    .rst_n  (arst_n),
    .ld     (enter),
    .ld_val (run_n_d),
    .dec    (rc_dec),
    .last   (rc_last)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      st_q     <= IDLE;
      idx_q    <= '0;
      imem_n_q <= '0;
      dmem_n_q <= '0;
      run_n_q  <= '0;
      dump_n_q <= '0;
    end else begin
      st_q     <= st_d;
      idx_q    <= idx_d;
      imem_n_q <= imem_n_d;
      dmem_n_q <= dmem_n_d;
      run_n_q  <= run_n_d;
      dump_n_q <= dump_n_d;
    end
  end

  assign ld_i = (st_q == LOAD_I);
  assign ld_d = (st_q == LOAD_D);
  assign busy = (st_q != IDLE);
  assign done = (st_q == DONE) && !abort;
  assign enable = (st_q == RUN);

  assign host.in_ready = (ld_i || ld_d) && !abort;
  assign in_fire = host.in_ready && host.in_valid;

  assign wen_ext   = in_fire && ld_i;
  assign ren_ext   = 1'b0;
  assign wdata_ext = ld_i ? host.in_data[31:0] : '0;
  assign addr_ext  = ld_i ?
    64'(idx_q[IMEM_ADDR_W-1:0]) * 64'(IMEM_STRIDE) : '0;

  assign wen_ext_2   = in_fire && ld_d;
  assign wdata_ext_2 = ld_d ? host.in_data : '0;
  assign addr_ext_2  = dm_addr_on ?
    64'(idx_q) * 64'(DMEM_STRIDE) : '0;

`ifdef CPU_BOOT_DUMP_EN
  logic [63:0] out_data_q, out_data_d;

  assign dm_addr_on = ld_d || (st_q == DUMP_RD);
  assign ren_ext_2 = (st_q == DUMP_RD);
  assign host.out_valid = (st_q == DUMP_OUT) && !abort;
  assign host.out_data = out_data_q;
  assign out_fire = host.out_valid && host.out_ready;
  assign out_data_d = (st_q == DUMP_WAIT) ? rdata_ext_2 : out_data_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) out_data_q <= '0;
    else out_data_q <= out_data_d;
  end
`else
  logic unused_dump;

  assign dm_addr_on = ld_d;
  assign ren_ext_2 = 1'b0;
  assign host.out_valid = 1'b0;
  assign host.out_data = '0;
  assign out_fire = 1'b0;
  assign unused_dump = ^{dump_n_q, host.out_ready, rdata_ext_2, out_fire};
`endif
endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// tb_cpu_boot_ctrl: scoreboard bench for cpu_boot_ctrl load/run/dump.
// Dump checks are built only with CPU_BOOT_DUMP_EN.
module tb_cpu_boot_ctrl;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start, abort;
  logic [9:0]  imem_words;
  logic [10:0] dmem_words;
  logic [31:0] run_cycles;
  logic [10:0] dump_words;
  logic        enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic        busy, done;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
  logic [63:0] rdata_ext_2 = '0;
  logic [31:0] wdata_ext;

  cpu_boot_if bus ();

  always #5 clk = ~clk;

  cpu_boot_ctrl dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .start       (start),
    .abort       (abort),
    .imem_words  (imem_words),
    .dmem_words  (dmem_words),
    .run_cycles  (run_cycles),
    .dump_words  (dump_words),
    .host        (bus),
    .enable      (enable),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2),
    .busy        (busy),
    .done        (done)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         iq[$];
  wr_t         dq[$];
  logic [63:0] oq[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          n_dwr = 0;
  logic [63:0] dmem [1024];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] outs_or();
    return {|addr_ext, |addr_ext_2, |wdata_ext, |wdata_ext_2,
            |bus.out_data, enable, wen_ext, ren_ext, wen_ext_2,
            ren_ext_2, busy, done, bus.in_ready, bus.out_valid};
  endfunction

  // the cpu's data memory with a one-cycle registered read
  always @(posedge clk) begin
    if (wen_ext_2) dmem[addr_ext_2[12:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];
  end

  always @(negedge clk) begin
    wr_t e;
    if (wen_ext) begin
      if (iq.size() == 0) chk("imem_unexp_wr", wen_ext, 0);
      else begin
        e = iq.pop_front();
        chk("imem_addr", addr_ext, e.addr);
        chk("imem_data", {32'h0, wdata_ext}, e.data);
      end
    end
    if (wen_ext_2) begin
      n_dwr++;
      if (dq.size() == 0) chk("dmem_unexp_wr", wen_ext_2, 0);
      else begin
        e = dq.pop_front();
        chk("dmem_addr", addr_ext_2, e.addr);
        chk("dmem_data", wdata_ext_2, e.data);
      end
    end
    if (bus.out_valid && bus.out_ready) begin
      if (oq.size() == 0) chk("out_unexp", bus.out_valid, 0);
      else chk("out_data", bus.out_data, oq.pop_front());
    end
    if (enable)
      chk("run_quiet", {wen_ext, ren_ext, wen_ext_2, ren_ext_2,
                        bus.in_ready, bus.out_valid}, 0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input int ni, input int nd, input int nr,
                      input int np);
    imem_words = 10'(ni);
    dmem_words = 11'(nd);
    run_cycles = 32'(nr);
    dump_words = 11'(np);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input bit to_imem,
                      input int k);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    if (to_imem) iq.push_back('{64'(4 * k), {32'h0, d[31:0]}});
    else dq.push_back('{64'(8 * k), d});
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("in_handshake", ok, 1);
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_done(input string tag, input int lat);
    int n;
    n = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (done) begin
        n = t;
        break;
      end
    end
    chk({tag, "_done_lat"}, 64'(n), 64'(lat));
    @(negedge clk);
    chk({tag, "_done_1cyc"}, {done, busy}, 0);
    cyc();
  endtask

  task automatic wait_out(input string tag);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    bit seen;
    start = 0;
    abort = 0;
    imem_words = '0;
    dmem_words = '0;
    run_cycles = '0;
    dump_words = '0;
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", outs_or(), 0);
    arst_n = 1'b1;
    cyc();

    // three imem words back to back
    kick(3, 0, 0, 0);
    for (int k = 0; k < 3; k++) send(64'h13, 1'b1, k);
    expect_done("t1", 0);
    chk("t1_iq_empty", iq.size(), 0);

    // two dmem words with a one-cycle gap
    base = n_dwr;
    kick(0, 2, 0, 0);
    send(64'h0123_4567_89AB_CDEF, 1'b0, 0);
    @(negedge clk);
    chk("t2_gap_ready", bus.in_ready, 1);
    cyc();
    send(64'hFEDC_BA98_7654_3210, 1'b0, 1);
    expect_done("t2", 0);
    chk("t2_nwr", n_dwr - base, 2);
    chk("t2_dq_empty", dq.size(), 0);

    // run only
    kick(0, 0, 5, 0);
    n = 0;
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (t == 0) chk("t3_en_rise", enable, 1);
      if (enable) n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t3_en_len", n, 5);
    chk("t3_done", seen, 1);
    @(negedge clk);
    chk("t3_idle", {done, busy, enable}, 0);
    cyc();

`ifdef CPU_BOOT_DUMP_EN
    // load two dmem words, dump them, stall on the second
    oq.push_back(64'h1111_2222_3333_4444);
    oq.push_back(64'hDEAD_BEEF_0000_0001);
    kick(0, 2, 0, 2);
    send(64'h1111_2222_3333_4444, 1'b0, 0);
    send(64'hDEAD_BEEF_0000_0001, 1'b0, 1);
    wait_out("t4_out0");
    cyc();
    bus.out_ready = 1'b0;
    wait_out("t4_out1");
    chk("t4_hold", bus.out_data, 64'hDEAD_BEEF_0000_0001);
    for (int s = 0; s < 3; s++) begin
      cyc();
      @(negedge clk);
      chk("t4_hold", bus.out_data, 64'hDEAD_BEEF_0000_0001);
      chk("t4_hold_valid", bus.out_valid, 1);
    end
    cyc();
    bus.out_ready = 1'b1;
    expect_done("t4", 1);
    chk("t4_oq_empty", oq.size(), 0);
`else
    // dump count is ignored without the dump phase
    kick(0, 0, 0, 3);
    @(negedge clk);
    chk("t4_nodump_done", done, 1);
    chk("t4_nodump_ov", {bus.out_valid, ren_ext_2}, 0);
    cyc();
    @(negedge clk);
    chk("t4_nodump_idle", busy, 0);
    cyc();
`endif

    // abort on the second imem word
    kick(3, 0, 0, 0);
    send(64'h13, 1'b1, 0);
    bus.in_valid = 1'b1;
    bus.in_data = 64'h0000_0000_0000_0BAD;
    abort = 1'b1;
    @(negedge clk);
    chk("t5_abort_wen", wen_ext, 0);
    chk("t5_abort_rdy", bus.in_ready, 0);
    cyc();
    abort = 1'b0;
    bus.in_valid = 1'b0;
    n = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (t == 0) chk("t5_idle", busy, 0);
      if (done) n++;
    end
    chk("t5_no_done", n, 0);
    cyc();

    // abort beats start in idle
    abort = 1'b1;
    kick(3, 0, 0, 0);
    abort = 1'b0;
    @(negedge clk);
    chk("t5b_start_abort", busy, 0);
    cyc();

    // full imem depth
    kick(512, 0, 0, 0);
    for (int k = 0; k < 512; k++)
      send(64'hA000_0000 + 64'(k), 1'b1, k);
    expect_done("t6", 0);
    chk("t6_iq_empty", iq.size(), 0);

    // async reset during run, then a normal load
    kick(0, 0, 50, 0);
    repeat (3) cyc();
    @(negedge clk);
    chk("t7_running", enable, 1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("t7_rst_outs", outs_or(), 0);
    cyc();
    arst_n = 1'b1;
    cyc();
    kick(2, 0, 0, 0);
    send(64'h0000_0000_0010_0093, 1'b1, 0);
    send(64'h0000_0000_0020_0113, 1'b1, 1);
    expect_done("t7", 0);
    chk("t7_iq_empty", iq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
